// File: rtl/cms_trace_stream_receiver.sv
`default_nettype none
// ============================================================================
// Module      : cms_trace_stream_receiver
// Description : Sink end of the continuous-monitoring trace AXI-Stream.
//               Accepts {pc, instr} beats into a small FIFO and presents the
//               head beat unpacked on a valid/ready output. Counts accepted
//               beats and bursts and flags tlast framing errors against an
//               expected burst length.
// Ports       :
//   clk, rst_n                     clock, asynchronous active-low reset
//   S_AXIS_tvalid/tready/tdata/tlast  trace stream input
//   tlast_interval                 expected beats per burst (0 = no check)
//   rx_enable                      0 holds S_AXIS_tready low
//   out_valid/out_ready            unpacked beat handshake
//   out_pc/out_instr/out_last      head beat fields (0 while empty)
//   fifo_level                     entries currently buffered
//   beat_count/burst_count         accepted beats / accepted tlast beats
//   err_tlast_early/err_tlast_late sticky framing errors
//   err_clear                      clears both sticky errors
// Revision    : 1.0 - initial release
// ============================================================================
module cms_trace_stream_receiver #(
  parameter int XLEN           = 64,
  parameter int AXI_DATA_WIDTH = 96,
  parameter int FIFO_DEPTH     = 8,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0]     S_AXIS_tdata,
  input  logic                          S_AXIS_tlast,
  input  logic [CNT_WIDTH-1:0]          tlast_interval,
  input  logic                          rx_enable,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [31:0]                   out_instr,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [31:0]                   beat_count,
  output logic [CNT_WIDTH-1:0]          burst_count,
  output logic                          err_tlast_early,
  output logic                          err_tlast_late,
  input  logic                          err_clear
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);

  // Beat storage: data only, no reset needed since the head is masked
  // whenever the level is zero.
  logic [XLEN-1:0]       mem_pc    [FIFO_DEPTH];
  logic [31:0]           mem_instr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;
  logic                  active;
  logic                  push;
  logic                  pop;

  logic [CNT_WIDTH-1:0]  beat_in_burst;
  logic [CNT_WIDTH-1:0]  idx;
  logic                  check_on;
  logic                  set_early;
  logic                  set_late;
  logic                  end_burst;

  // 'active' is a registered out-of-reset flag so tready is held low while
  // rst_n is asserted even though the level reads zero then.
  assign S_AXIS_tready = active & rx_enable & (level != FULL_LEVEL);
  assign push          = S_AXIS_tvalid & S_AXIS_tready;
  assign out_valid     = (level != '0);
  assign pop           = out_valid & out_ready;
  assign fifo_level    = level;

  assign out_pc    = out_valid ? mem_pc[rd_ptr]    : '0;
  assign out_instr = out_valid ? mem_instr[rd_ptr] : '0;
  assign out_last  = out_valid ? mem_last[rd_ptr]  : 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= S_AXIS_tdata[XLEN+31:32];
      mem_instr[wr_ptr] <= S_AXIS_tdata[31:0];
      mem_last[wr_ptr]  <= S_AXIS_tlast;
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      active <= 1'b0;
    end else begin
      active <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Framing check: idx is the 1-based position of the beat being accepted.
  assign idx       = beat_in_burst + CNT_WIDTH'(1);
  assign check_on  = (tlast_interval != '0);
  assign set_early = push & check_on &  S_AXIS_tlast & (idx <  tlast_interval);
  assign set_late  = push & check_on & ~S_AXIS_tlast & (idx == tlast_interval);
  // Reaching the interval without tlast still restarts the count so a single
  // missing tlast does not misalign every following burst.
  assign end_burst = S_AXIS_tlast | (check_on & (idx == tlast_interval));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_count    <= '0;
      burst_count   <= '0;
      beat_in_burst <= '0;
    end else if (push) begin
      beat_count    <= beat_count + 32'd1;
      beat_in_burst <= end_burst ? '0 : idx;
      if (S_AXIS_tlast) burst_count <= burst_count + CNT_WIDTH'(1);
    end
  end

  // A new error in the same cycle as err_clear takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_tlast_early <= 1'b0;
      err_tlast_late  <= 1'b0;
    end else begin
      err_tlast_early <= set_early | (err_tlast_early & ~err_clear);
      err_tlast_late  <= set_late  | (err_tlast_late  & ~err_clear);
    end
  end

endmodule
`default_nettype wire
